// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: data widths, byte-lane enables and the
// memory-stage run/halt state.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [3:0] byte_en_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } stage_state_e;

  // One-hot lane enable for a byte store at the given byte offset.
  function automatic byte_en_t lane_mask(input logic [1:0] lane);
    return byte_en_t'(4'b0001 << lane);
  endfunction

endpackage

// File: rtl/data_memory.sv
// MEM_WORDS x 32-bit data memory: per-byte write enables and a registered,
// read-first read port (a same-edge write is visible on the following read).
module data_memory
  import riscv_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  localparam int AW       = $clog2(MEM_WORDS)
) (
  input  logic            clock,
  input  logic [AW-1:0]   addr,
  input  byte_en_t        byte_en,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem [MEM_WORDS];
  logic [XLEN-1:0] rdata_d, rdata_q;

  always_comb begin
    rdata_d = mem[addr];
  end

  // NOTE: the array has no reset on purpose; clearing it would need a
  // multi-cycle sweep and the contents must survive reset anyway.
  always_ff @(posedge clock) begin
    rdata_q <= rdata_d;
    for (int lane = 0; lane < 4; lane++) begin
      if (byte_en[lane]) mem[addr][8*lane +: 8] <= wdata[8*lane +: 8];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// RISC-V MEM stage: word/byte stores, word/halfword loads, MEM/WB registers and
// a sticky halt. Define MEM_MISALIGN_TRAP_EN to trap misaligned word/half accesses.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  localparam int AW       = $clog2(MEM_WORDS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  regWrite_in,
  input  logic                  memtoReg_in,
  input  logic                  memWrite_in,
  input  logic                  sb_in,
  input  logic                  lh_in,
  input  logic [XLEN-1:0]       readData2_in,
  input  logic [XLEN-1:0]       ALUresult_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  halt_in,
  output logic                  regWrite,
  output logic                  memtoReg,
  output logic [XLEN-1:0]       readData,
  output logic [XLEN-1:0]       ALUresult,
  output logic [REG_ADDR_W-1:0] rd,
  output logic                  halt,
  output logic                  misaligned
);

  stage_state_e          state_d, state_q;
  logic                  regWrite_d, regWrite_q;
  logic                  memtoReg_d, memtoReg_q;
  logic                  lh_d, lh_q;
  logic                  hi_half_d, hi_half_q;
  logic [XLEN-1:0]       ALUresult_d, ALUresult_q;
  logic [REG_ADDR_W-1:0] rd_d, rd_q;
  logic                  halt_d, halt_q;

  logic [AW-1:0]   word_addr;
  logic [1:0]      lane;
  logic            mis_access;
  logic            write_ok;
  byte_en_t        byte_en;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;
  logic [15:0]     half;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    word_addr = ALUresult_in[AW+1:2];
    lane      = ALUresult_in[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
    mis_access = (((memWrite_in & ~sb_in) | (memtoReg_in & ~lh_in)) & (lane != 2'd0))
               | (memtoReg_in & lh_in & lane[0]);
`else
    mis_access = 1'b0;
`endif

    // Reset is folded in so a store presented on a reset edge is dropped.
    write_ok = memWrite_in & (state_q == RUN) & ~mis_access & ~reset;
    byte_en  = '0;
    if (write_ok) byte_en = sb_in ? lane_mask(lane) : 4'hF;
    wdata = sb_in ? {4{readData2_in[7:0]}} : readData2_in;

    state_d = state_q;
    if (halt_in) state_d = HALTED;

    regWrite_d  = regWrite_in & (state_q == RUN) & ~mis_access;
    memtoReg_d  = memtoReg_in;
    lh_d        = lh_in;
    hi_half_d   = lane[1];
    ALUresult_d = ALUresult_in;
    rd_d        = rd_in;
    halt_d      = halt_in;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      regWrite_q  <= 1'b0;
      memtoReg_q  <= 1'b0;
      lh_q        <= 1'b0;
      hi_half_q   <= 1'b0;
      ALUresult_q <= '0;
      rd_q        <= '0;
      halt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      regWrite_q  <= regWrite_d;
      memtoReg_q  <= memtoReg_d;
      lh_q        <= lh_d;
      hi_half_q   <= hi_half_d;
      ALUresult_q <= ALUresult_d;
      rd_q        <= rd_d;
      halt_q      <= halt_d;
    end
  end

  data_memory #(.MEM_WORDS(MEM_WORDS)) u_dmem (
    .clock   (clock),
    .addr    (word_addr),
    .byte_en (byte_en),
    .wdata   (wdata),
    .rdata   (rdata)
  );

  // Load extension works on the registered read word and registered selects.
  always_comb begin
    half     = hi_half_q ? rdata[31:16] : rdata[15:0];
    readData = '0;
    if (memtoReg_q) readData = lh_q ? {{16{half[15]}}, half} : rdata;
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned_d, misaligned_q;

  always_comb begin
    misaligned_d = misaligned_q | mis_access;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) misaligned_q <= 1'b0;
    else       misaligned_q <= misaligned_d;
  end

  assign misaligned = misaligned_q;
`else
  assign misaligned = 1'b0;
`endif

  assign regWrite  = regWrite_q;
  assign memtoReg  = memtoReg_q;
  assign ALUresult = ALUresult_q;
  assign rd        = rd_q;
  assign halt      = halt_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a word-level memory model checked every
// cycle, plus literal expectations from the hand-worked load/store scenarios.
module tb_mem_stage;

  localparam int MEM_WORDS = 1024;

  logic        clock = 1'b0;
  logic        reset;
  logic        regWrite_in, memtoReg_in, memWrite_in, sb_in, lh_in, halt_in;
  logic [31:0] readData2_in, ALUresult_in;
  logic [4:0]  rd_in;
  logic        regWrite, memtoReg, halt, misaligned;
  logic [31:0] readData, ALUresult;
  logic [4:0]  rd;

  mem_stage #(.MEM_WORDS(MEM_WORDS)) dut (
    .clock        (clock),
    .reset        (reset),
    .regWrite_in  (regWrite_in),
    .memtoReg_in  (memtoReg_in),
    .memWrite_in  (memWrite_in),
    .sb_in        (sb_in),
    .lh_in        (lh_in),
    .readData2_in (readData2_in),
    .ALUresult_in (ALUresult_in),
    .rd_in        (rd_in),
    .halt_in      (halt_in),
    .regWrite     (regWrite),
    .memtoReg     (memtoReg),
    .readData     (readData),
    .ALUresult    (ALUresult),
    .rd           (rd),
    .halt         (halt),
    .misaligned   (misaligned)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // Reference model: memory as a word-indexed associative array.
  logic [31:0] m_mem [int];
  logic        m_halted, m_mis;
  logic        e_regWrite, e_memtoReg, e_halt;
  logic [31:0] e_readData, e_ALUresult;
  logic [4:0]  e_rd;

  always @(posedge clock or posedge reset) begin
    int          idx;
    int          lane;
    logic [31:0] word;
    logic [15:0] hw;
    logic        bad;
    if (reset) begin
      m_halted = 0; m_mis = 0;
      e_regWrite = 0; e_memtoReg = 0; e_halt = 0;
      e_readData = 0; e_ALUresult = 0; e_rd = 0;
    end else begin
      idx  = int'((ALUresult_in >> 2) % MEM_WORDS);
      lane = int'(ALUresult_in % 4);
      word = m_mem.exists(idx) ? m_mem[idx] : 32'hxxxx_xxxx;
      bad  = TRAP && ((((memWrite_in && !sb_in) || (memtoReg_in && !lh_in)) && lane != 0)
                      || (memtoReg_in && lh_in && (lane % 2) == 1));
      hw   = (lane >= 2) ? word[31:16] : word[15:0];
      if (!memtoReg_in)  e_readData = 0;
      else if (lh_in)    e_readData = 32'($signed(hw));
      else               e_readData = word;
      if (memWrite_in && !m_halted && !bad) begin
        if (sb_in) begin
          word[8*lane +: 8] = readData2_in[7:0];
          m_mem[idx] = word;
        end else begin
          m_mem[idx] = readData2_in;
        end
      end
      e_regWrite  = regWrite_in && !m_halted && !bad;
      e_memtoReg  = memtoReg_in;
      e_ALUresult = ALUresult_in;
      e_rd        = rd_in;
      e_halt      = halt_in;
      m_mis       = m_mis || bad;
      m_halted    = m_halted || halt_in;
    end
  end

  logic chk_en = 1'b0;

  always @(negedge clock) begin
    if (chk_en) begin
      check("regWrite",   regWrite,   e_regWrite);
      check("memtoReg",   memtoReg,   e_memtoReg);
      check("readData",   readData,   e_readData);
      check("ALUresult",  ALUresult,  e_ALUresult);
      check("rd",         rd,         e_rd);
      check("halt",       halt,       e_halt);
      check("misaligned", misaligned, m_mis);
    end
  end

  task automatic set_in(input logic rw, mr, mw, sb, lh, input logic [31:0] a, d,
                        input logic [4:0] r, input logic h);
    regWrite_in = rw; memtoReg_in = mr; memWrite_in = mw; sb_in = sb; lh_in = lh;
    ALUresult_in = a; readData2_in = d; rd_in = r; halt_in = h;
  endtask

  task automatic issue(input logic rw, mr, mw, sb, lh, input logic [31:0] a, d,
                       input logic [4:0] r, input logic h);
    set_in(rw, mr, mw, sb, lh, a, d, r, h);
    @(negedge clock);
  endtask

  task automatic sw(input logic [31:0] a, d);  issue(0, 0, 1, 0, 0, a, d, 0, 0); endtask
  task automatic sbt(input logic [31:0] a, d); issue(0, 0, 1, 1, 0, a, d, 0, 0); endtask
  task automatic lw(input logic [31:0] a, input logic [4:0] r); issue(1, 1, 0, 0, 0, a, 0, r, 0); endtask
  task automatic lh(input logic [31:0] a, input logic [4:0] r); issue(1, 1, 0, 0, 1, a, 0, r, 0); endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clock);
    chk_en = 1'b1;
    @(negedge clock);
    check("rst_readData", readData, 32'h0);
    check("rst_regWrite", regWrite, 32'h0);
    reset = 1'b0;

    // Store word then load it back.
    sw(32'h10, 32'hDEADBEEF);
    lw(32'h10, 5'd5);
    check("lit_lw_10", readData, 32'hDEADBEEF);
    check("lit_rd_10", rd, 32'd5);
    check("lit_rw_10", regWrite, 32'd1);

    // Byte store merges into one lane.
    sw(32'h20, 32'h11223344);
    sbt(32'h22, 32'h000000AA);
    lw(32'h20, 5'd6);
    check("lit_sb_merge", readData, 32'h11AA3344);

    // sb/lh without memWrite/memtoReg do nothing.
    issue(1, 0, 0, 1, 1, 32'h20, 32'hFFFFFFFF, 5'd7, 0);
    check("lit_noload_zero", readData, 32'h0);
    lw(32'h20, 5'd6);
    check("lit_nostore", readData, 32'h11AA3344);

    // Halfword loads with sign extension.
    sw(32'h30, 32'h80017FFF);
    lh(32'h30, 5'd8);
    check("lit_lh_lo", readData, 32'h00007FFF);
    lh(32'h32, 5'd8);
    check("lit_lh_hi", readData, 32'hFFFF8001);

    // Address wraps modulo 4*MEM_WORDS bytes.
    sw(32'(4 * MEM_WORDS + 8), 32'hCAFEF00D);
    lw(32'h8, 5'd9);
    check("lit_wrap", readData, 32'hCAFEF00D);

    // Misaligned word store.
    sw(32'h40, 32'h12345678);
    sw(32'h41, 32'h9ABCDEF0);
    lw(32'h40, 5'd10);
    check("lit_mis_data", readData, TRAP ? 32'h12345678 : 32'h9ABCDEF0);
    check("lit_mis_flag", misaligned, 32'(TRAP));
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("lit_mis_sticky", misaligned, 32'(TRAP));

    // Preload words used after halt and reset.
    sw(32'h54, 32'h0BADF00D);
    sw(32'h60, 32'h600D600D);

    // Halt: its own store completes, later stores and regWrite are blocked.
    issue(1, 0, 1, 0, 0, 32'h50, 32'hAAAA5555, 5'd11, 1);
    check("lit_halt_rw", regWrite, 32'd1);
    check("lit_halt_flag", halt, 32'd1);
    issue(1, 0, 1, 0, 0, 32'h54, 32'h00000055, 5'd12, 0);
    check("lit_halted_rw", regWrite, 32'd0);
    lw(32'h50, 5'd13);
    check("lit_halt_store", readData, 32'hAAAA5555);
    lw(32'h54, 5'd14);
    check("lit_halted_nostore", readData, 32'h0BADF00D);
    check("lit_halted_lw_rw", regWrite, 32'd0);

    // Reset with a store pending: store dropped, outputs cleared, back to RUN.
    #2;
    reset = 1'b1;
    set_in(1, 0, 1, 0, 0, 32'h60, 32'h11111111, 5'd15, 0);
    @(negedge clock);
    check("lit_rst_rw", regWrite, 32'h0);
    check("lit_rst_alu", ALUresult, 32'h0);
    check("lit_rst_halt", halt, 32'h0);
    check("lit_rst_mis", misaligned, 32'h0);
    reset = 1'b0;
    issue(1, 0, 1, 0, 0, 32'h64, 32'h13579BDF, 5'd3, 0);
    check("lit_run_rw", regWrite, 32'd1);
    lw(32'h60, 5'd4);
    check("lit_rst_nostore", readData, 32'h600D600D);
    lw(32'h64, 5'd4);
    check("lit_post_rst", readData, 32'h13579BDF);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RISC-V pipeline, directly downstream of the EX/MEM register. Consumes EX/MEM control and data and performs word/byte stores and word/halfword loads against an internal data memory. Registers results into MEM/WB outputs for the write-back stage. A sticky halt state freezes memory writes after a halt instruction retires through this stage.

## Interface
- MEM_WORDS, 1024, data memory depth in 32-bit words; power of two.
- clock  input  1  stage clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high
- regWrite_in, memtoReg_in, memWrite_in, sb_in, lh_in  input  1 each  control from EX/MEM
- readData2_in  input  32  store data
- ALUresult_in  input  32  byte address / ALU result
- rd_in  input  5  destination register
- halt_in  input  1  halt marker from EX/MEM
- regWrite, memtoReg  output  1 each  registered control to write-back
- readData  output  32  registered load result
- ALUresult  output  32  registered pass-through of ALUresult_in
- rd  output  5  registered destination register
- halt  output  1  registered halt marker
- misaligned  output  1  sticky misaligned-access flag; constant 0 when the feature is compiled out

## Operation
- Word index = ALUresult_in[log2(MEM_WORDS)+1:2]; upper address bits ignored, so addresses wrap modulo 4*MEM_WORDS bytes.
- Store word: memWrite_in=1, sb_in=0 → whole word written with readData2_in.
- Store byte: memWrite_in=1, sb_in=1 → only the lane ALUresult_in[1:0] written, with readData2_in[7:0]; other lanes unchanged.
- Load word: memtoReg_in=1, lh_in=0 → readData = addressed word.
- Load half: memtoReg_in=1, lh_in=1 → halfword at ALUresult_in[1] (0 = bits 15:0, 1 = bits 31:16), sign-extended to 32 bits.
- memtoReg_in=0 → readData = 0.
- Control bits sb_in/lh_in without memWrite_in/memtoReg_in: no effect.
- State machine, two states:
  - RUN: normal operation. A captured halt_in=1 moves the block to HALTED on the same edge; that instruction's own store, if any, still completes.
  - HALTED: all memory writes suppressed, regWrite output forced 0. Loads still return data. Only reset leaves HALTED.
- Memory contents are not cleared by reset.

## Timing
- One-cycle latency: inputs sampled at edge N appear on all outputs after edge N; the store is committed at the same edge N.
- Synchronous-read memory. A store at edge N followed by a load of the same address at edge N+1 returns the new data.
- No handshake; the stage accepts one instruction every cycle.
- Reset values: regWrite=0, memtoReg=0, readData=0, ALUresult=0, rd=0, halt=0, misaligned=0, state=RUN.
- A store presented on the same edge that reset is asserted is not performed.
- Reset deasserted mid-stream: the first edge after deassertion processes inputs normally.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - Misalignment conditions: lw/sw with ALUresult_in[1:0]≠0, or lh with ALUresult_in[0]=1.
  - On a misaligned access: memory write suppressed, regWrite output 0 for that instruction, misaligned set and held until reset.
- MEM_MISALIGN_TRAP_EN undefined:
  - Word accesses ignore address bits [1:0]; lh ignores bit 0.
  - misaligned tied to 0.

## Structure
- Shared package riscv_pkg:
  - Constants: XLEN=32, REG_ADDR_W=5.
  - Byte-lane enable type (4 bits).
  - Stage-state enum {RUN, HALTED}.
- Sub-module data_memory: MEM_WORDS×32 array with 4-bit byte write enables and a registered read port. mem_stage holds the control, extension logic, and output registers.

## Test plan
- sw 0xDEADBEEF to addr 0x10, then lw addr 0x10 → readData=0xDEADBEEF one cycle after the load's input edge; regWrite/rd pass through unchanged.
- sw 0x11223344 to 0x20; sb readData2_in=0xAA at 0x22; lw 0x20 → 0x11AA3344.
- Memory word 0x8001_7FFF at 0x30: lh 0x30 → 0x00007FFF; lh 0x32 → 0xFFFF8001.
- halt_in=1 with a sw to 0x40; then sw 0x55 to 0x44 → 0x40 written, 0x44 unchanged, halt=1, later regWrite=0; reset returns to RUN with all outputs 0.
- With MEM_MISALIGN_TRAP_EN: sw to 0x41 → memory unchanged, misaligned=1 and sticky. Without it: same sw writes word 0x40.
- Address 4*MEM_WORDS+8: sw then lw at 8 → same data (wrap-around).
